dtcm_responder: RTL and testbench



---
 rtl/dtcm_pkg.sv | 73 +++++++
 rtl/dtcm_responder_if.sv | 19 +
 rtl/dtcm_timer.sv | 74 +++++++
 rtl/dtcm_responder.sv | 198 +++++++++++++++++++
 tb/tb_dtcm_responder.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/dtcm_pkg.sv
// Shared types and constants for the dtcm_responder data-memory port.
// Timer registers are only present when DTCM_TIMER_EN is defined.
package dtcm_pkg;

    typedef enum logic [2:0] {
        LS_B  = 3'b000,
        LS_H  = 3'b001,
        LS_W  = 3'b010,
        LS_BU = 3'b100,
        LS_HU = 3'b101
    } ls_type_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } ls_size_e;

    localparam logic [7:0] OFF_TOHOST      = 8'h00;
    localparam logic [7:0] OFF_MTIME_LO    = 8'h04;
    localparam logic [7:0] OFF_MTIME_HI    = 8'h08;
    localparam logic [7:0] OFF_MTIMECMP_LO = 8'h0C;
    localparam logic [7:0] OFF_MTIMECMP_HI = 8'h10;
    localparam logic [7:0] OFF_ERR_STATUS  = 8'h14;
    localparam logic [7:0] OFF_ERR_ADDR    = 8'h18;
    localparam logic [7:0] OFF_ERR_CLEAR   = 8'h1C;

    localparam int ERR_MISALIGN = 0;
    localparam int ERR_RANGE    = 1;
    localparam int ERR_SUBWORD  = 2;

    localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

    // Signedness lives in funct3[2] and is applied by the core, so only the size matters here.
    function automatic ls_size_e accessSize(input logic [2:0] rwType);
        ls_size_e sz;
        case (rwType[1:0])
            2'b00:   sz = SZ_BYTE;
            2'b01:   sz = SZ_HALF;
            default: sz = SZ_WORD;
        endcase
        return sz;
    endfunction

    function automatic logic [3:0] byteEnable(input ls_size_e sz, input logic [1:0] a);
        logic [3:0] be;
        case (sz)
            SZ_BYTE: be = 4'b0001 << a;
            SZ_HALF: be = a[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] laneExtract(input logic [31:0] w, input ls_size_e sz,
                                                input logic [1:0] a);
        logic [31:0] r;
        case (sz)
            SZ_BYTE: begin
                case (a)
                    2'd0:    r = {24'd0, w[7:0]};
                    2'd1:    r = {24'd0, w[15:8]};
                    2'd2:    r = {24'd0, w[23:16]};
                    default: r = {24'd0, w[31:24]};
                endcase
            end
            SZ_HALF: r = a[1] ? {16'd0, w[31:16]} : {16'd0, w[15:0]};
            default: r = w;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dtcm_responder_if.sv
// Core-to-responder data-memory bus: request fields from the core, load data back.
interface dtcm_responder_if;
    logic        dtcm_mem_write;
    logic        dtcm_mem_read;
    logic [31:0] dtcm_addr;
    logic [31:0] dtcm_dataout;
    logic [2:0]  dtcm_RW_type;
    logic [31:0] dtcm_datain;

    modport master (
        output dtcm_mem_write, dtcm_mem_read, dtcm_addr, dtcm_dataout, dtcm_RW_type,
        input  dtcm_datain
    );

    modport slave (
        input  dtcm_mem_write, dtcm_mem_read, dtcm_addr, dtcm_dataout, dtcm_RW_type,
        output dtcm_datain
    );
endinterface

// File: rtl/dtcm_timer.sv
// Machine timer: prescaler, 64-bit mtime, mtimecmp, tear-free hi shadow and irq register.
// Instantiated by dtcm_responder only when DTCM_TIMER_EN is defined.
module dtcm_timer
    import dtcm_pkg::*;
#(
    parameter int TICK_DIV = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we_i,
    input  logic        re_i,
    input  logic [1:0]  sel_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        irq_o
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PW-1:0] presc_q, presc_d;
    logic [63:0]   mtime_q, mtime_d;
    logic [63:0]   cmp_q, cmp_d;
    logic [31:0]   shadow_q, shadow_d;
    logic          irq_q;
    logic          tick;

    // A software write to an mtime half overrides the tick for that cycle.
    always_comb begin
        tick     = (presc_q == PW'(TICK_DIV - 1));
        presc_d  = tick ? '0 : presc_q + 1'b1;
        mtime_d  = tick ? mtime_q + 64'd1 : mtime_q;
        cmp_d    = cmp_q;
        shadow_d = shadow_q;
        if (we_i) begin
            case (sel_i)
                2'd0:    mtime_d = {mtime_q[63:32], wdata_i};
                2'd1:    mtime_d = {wdata_i, mtime_q[31:0]};
                2'd2:    cmp_d   = {cmp_q[63:32], wdata_i};
                default: cmp_d   = {wdata_i, cmp_q[31:0]};
            endcase
        end
        if (re_i && sel_i == 2'd0) begin
            shadow_d = mtime_q[63:32];
        end
    end

    always_comb begin
        case (sel_i)
            2'd0:    rdata_o = mtime_q[31:0];
            2'd1:    rdata_o = shadow_q;
            2'd2:    rdata_o = cmp_q[31:0];
            default: rdata_o = cmp_q[63:32];
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q  <= '0;
            mtime_q  <= '0;
            cmp_q    <= MTIMECMP_RST;
            shadow_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            presc_q  <= presc_d;
            mtime_q  <= mtime_d;
            cmp_q    <= cmp_d;
            shadow_q <= shadow_d;
            irq_q    <= (mtime_q >= cmp_q);
        end
    end

    assign irq_o = irq_q;

endmodule

// File: rtl/dtcm_responder.sv
// Data-memory responder: word RAM plus MMIO (tohost, error status, optional timer).
// Define DTCM_TIMER_EN to include the machine timer at offsets 0x04-0x10.
module dtcm_responder
    import dtcm_pkg::*;
#(
    parameter int         DEPTH     = 4096,
    parameter int         TICK_DIV  = 1,
    parameter logic [3:0] MMIO_BASE = 4'hF
) (
    input  logic              clk,
    input  logic              rst_n,
    dtcm_responder_if.slave   bus,
    output logic              timer_irq,
    output logic [31:0]       tohost,
    output logic              tohost_valid,
    output logic              bus_err
);

    localparam int          IW         = $clog2(DEPTH);
    localparam logic [27:0] RANGE_MASK = ~((28'(DEPTH) << 2) - 28'd1);

    if ((DEPTH & (DEPTH - 1)) != 0 || DEPTH < 2 || DEPTH > (1 << 26) || TICK_DIV < 1) begin : gBadParams
        $error("dtcm_responder: DEPTH must be a power of two and TICK_DIV >= 1");
    end

    logic [31:0]   mem [DEPTH];

    ls_size_e      size;
    logic          isMmio;
    logic          misaligned;
    logic          outOfRange;
    logic          subWord;
    logic [2:0]    errBits;
    logic          errEvent;
    logic          okWrite;
    logic          okRead;
    logic          ramWe;
    logic          mmioWe;
    logic          errClear;
    logic [7:0]    offset;
    logic [IW-1:0] wordIdx;
    logic [3:0]    byteEn;
    logic [31:0]   wdataRep;
    logic [31:0]   ramWord;
    logic [31:0]   mmioRdata;
    logic [31:0]   timerRdata;

    logic [31:0]   tohost_q, tohost_d;
    logic          tohostValid_q, tohostValid_d;
    logic [2:0]    errStatus_q, errStatus_d;
    logic [31:0]   errAddr_q, errAddr_d;
    logic          busErr_q, busErr_d;

    // Address decode and error classification; a failing access is fully suppressed.
    always_comb begin
        size       = accessSize(bus.dtcm_RW_type);
        isMmio     = (bus.dtcm_addr[31:28] == MMIO_BASE);
        offset     = bus.dtcm_addr[7:0];
        wordIdx    = bus.dtcm_addr[IW+1:2];
        misaligned = (size == SZ_HALF && bus.dtcm_addr[0]) ||
                     (size == SZ_WORD && bus.dtcm_addr[1:0] != 2'b00);
        outOfRange = !isMmio && (|(bus.dtcm_addr[27:0] & RANGE_MASK));
        subWord    = isMmio && (size != SZ_WORD);
        errBits               = '0;
        errBits[ERR_MISALIGN] = misaligned;
        errBits[ERR_RANGE]    = outOfRange;
        errBits[ERR_SUBWORD]  = subWord;
        errEvent   = (bus.dtcm_mem_write || bus.dtcm_mem_read) && (|errBits);
        okWrite    = bus.dtcm_mem_write && !errEvent;
        okRead     = bus.dtcm_mem_read && !errEvent;
        ramWe      = okWrite && !isMmio;
        mmioWe     = okWrite && isMmio;
        errClear   = mmioWe && (offset == OFF_ERR_CLEAR);
        byteEn     = byteEnable(size, bus.dtcm_addr[1:0]);
        case (size)
            SZ_BYTE: wdataRep = {4{bus.dtcm_dataout[7:0]}};
            SZ_HALF: wdataRep = {2{bus.dtcm_dataout[15:0]}};
            default: wdataRep = bus.dtcm_dataout;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n && ramWe) begin
            for (int i = 0; i < 4; i++) begin
                if (byteEn[i]) begin
                    mem[wordIdx][8*i +: 8] <= wdataRep[8*i +: 8];
                end
            end
        end
    end

    assign ramWord = mem[wordIdx];

`ifdef DTCM_TIMER_EN
    logic       timerHit;
    logic [1:0] timerSel;
    logic       timerIrq;

    always_comb begin
        timerHit = 1'b1;
        timerSel = 2'd0;
        case (offset)
            OFF_MTIME_LO:    timerSel = 2'd0;
            OFF_MTIME_HI:    timerSel = 2'd1;
            OFF_MTIMECMP_LO: timerSel = 2'd2;
            OFF_MTIMECMP_HI: timerSel = 2'd3;
            default:         timerHit = 1'b0;
        endcase
    end

    dtcm_timer #(
        .TICK_DIV (TICK_DIV)
    ) uTimer (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (mmioWe && timerHit),
        .re_i    (okRead && isMmio && timerHit),
        .sel_i   (timerSel),
        .wdata_i (bus.dtcm_dataout),
        .rdata_o (timerRdata),
        .irq_o   (timerIrq)
    );

    assign timer_irq = timerIrq;
`else
    assign timerRdata = '0;
    assign timer_irq  = 1'b0;
`endif

    always_comb begin
        mmioRdata = '0;
        case (offset)
            OFF_TOHOST:      mmioRdata = tohost_q;
            OFF_MTIME_LO,
            OFF_MTIME_HI,
            OFF_MTIMECMP_LO,
            OFF_MTIMECMP_HI: mmioRdata = timerRdata;
            OFF_ERR_STATUS:  mmioRdata = {29'd0, errStatus_q};
            OFF_ERR_ADDR:    mmioRdata = errAddr_q;
            default:         mmioRdata = '0;
        endcase
    end

    always_comb begin
        bus.dtcm_datain = '0;
        if (okRead) begin
            bus.dtcm_datain = isMmio ? mmioRdata : laneExtract(ramWord, size, bus.dtcm_addr[1:0]);
        end
    end

    // A new error in the same cycle as err_clear wins; err_addr latches only the first failure.
    always_comb begin
        tohost_d      = tohost_q;
        tohostValid_d = tohostValid_q;
        errStatus_d   = errStatus_q;
        errAddr_d     = errAddr_q;
        busErr_d      = busErr_q;
        if (mmioWe && offset == OFF_TOHOST) begin
            tohost_d = bus.dtcm_dataout;
            if (bus.dtcm_dataout != 32'd0) begin
                tohostValid_d = 1'b1;
            end
        end
        if (errClear) begin
            errStatus_d = '0;
            errAddr_d   = '0;
            busErr_d    = 1'b0;
        end
        if (errEvent) begin
            errStatus_d = errStatus_d | errBits;
            if (!busErr_q || errClear) begin
                errAddr_d = bus.dtcm_addr;
            end
            busErr_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tohost_q      <= '0;
            tohostValid_q <= 1'b0;
            errStatus_q   <= '0;
            errAddr_q     <= '0;
            busErr_q      <= 1'b0;
        end else begin
            tohost_q      <= tohost_d;
            tohostValid_q <= tohostValid_d;
            errStatus_q   <= errStatus_d;
            errAddr_q     <= errAddr_d;
            busErr_q      <= busErr_d;
        end
    end

    assign tohost       = tohost_q;
    assign tohost_valid = tohostValid_q;
    assign bus_err      = busErr_q;

endmodule

// File: tb/tb_dtcm_responder.sv
// Directed self-checking bench for dtcm_responder; timer checks follow DTCM_TIMER_EN.
module tb_dtcm_responder;
    import dtcm_pkg::*;

    localparam logic [31:0] MMIO = 32'hF000_0000;

    logic        clk;
    logic        rst_n;
    logic        timer_irq;
    logic [31:0] tohost;
    logic        tohost_valid;
    logic        bus_err;
    logic [31:0] lastRead;
    int          checks;
    int          errors;

    dtcm_responder_if busIf ();

    dtcm_responder #(
        .DEPTH     (4096),
        .TICK_DIV  (1),
        .MMIO_BASE (4'hF)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (busIf),
        .timer_irq    (timer_irq),
        .tohost       (tohost),
        .tohost_valid (tohost_valid),
        .bus_err      (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One bus cycle; load data is captured mid-cycle, before the commit edge.
    task automatic applyStimulus(input logic wr, input logic rd, input logic [31:0] addr,
                                 input logic [31:0] data, input logic [2:0] rwType);
        busIf.dtcm_mem_write = wr;
        busIf.dtcm_mem_read  = rd;
        busIf.dtcm_addr      = addr;
        busIf.dtcm_dataout   = data;
        busIf.dtcm_RW_type   = rwType;
        #2;
        lastRead = busIf.dtcm_datain;
        @(posedge clk);
        #1;
        busIf.dtcm_mem_write = 1'b0;
        busIf.dtcm_mem_read  = 1'b0;
    endtask

    task automatic storeOp(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] rwType);
        applyStimulus(1'b1, 1'b0, addr, data, rwType);
    endtask

    task automatic loadCheck(input string tag, input logic [31:0] addr, input logic [2:0] rwType,
                             input logic [31:0] expected);
        applyStimulus(1'b0, 1'b1, addr, 32'd0, rwType);
        checkOutput(tag, lastRead, expected);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        busIf.dtcm_mem_write = 1'b0;
        busIf.dtcm_mem_read  = 1'b0;
        busIf.dtcm_addr      = 32'd0;
        busIf.dtcm_dataout   = 32'd0;
        busIf.dtcm_RW_type   = LS_W;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        $display("[TB] reset released");

        checkOutput("rst_irq", {31'd0, timer_irq}, 32'd0);
        checkOutput("rst_tohost", tohost, 32'd0);
        checkOutput("rst_tohost_valid", {31'd0, tohost_valid}, 32'd0);
        checkOutput("rst_bus_err", {31'd0, bus_err}, 32'd0);
        loadCheck("rst_err_status", MMIO + 32'h14, LS_W, 32'd0);

        storeOp(32'h100, 32'h1122_3344, LS_W);
        busIf.dtcm_addr = 32'h100;
        #1;
        checkOutput("no_read_zero", busIf.dtcm_datain, 32'd0);
        loadCheck("lw_100", 32'h100, LS_W, 32'h1122_3344);
        loadCheck("lbu_102", 32'h102, LS_BU, 32'h0000_0022);
        loadCheck("lhu_102", 32'h102, LS_HU, 32'h0000_1122);
        loadCheck("lb_103", 32'h103, LS_B, 32'h0000_0011);
        loadCheck("lh_100", 32'h100, LS_H, 32'h0000_3344);

        storeOp(32'h104, 32'h5566_7788, LS_W);
        storeOp(32'h101, 32'h0000_00AB, LS_B);
        loadCheck("sb_101", 32'h100, LS_W, 32'h1122_AB44);
        loadCheck("sb_other_word", 32'h104, LS_W, 32'h5566_7788);
        storeOp(32'h106, 32'h0000_BEEF, LS_H);
        loadCheck("sh_106", 32'h104, LS_W, 32'hBEEF_7788);
        storeOp(32'h3FFC, 32'hA5A5_A5A5, LS_W);
        loadCheck("lw_top_word", 32'h3FFC, LS_W, 32'hA5A5_A5A5);
        checkOutput("top_word_no_err", {31'd0, bus_err}, 32'd0);

        storeOp(32'h102, 32'hDEAD_BEEF, LS_W);
        checkOutput("misalign_bus_err", {31'd0, bus_err}, 32'd1);
        loadCheck("misalign_status", MMIO + 32'h14, LS_W, 32'h1);
        loadCheck("misalign_addr", MMIO + 32'h18, LS_W, 32'h102);
        loadCheck("misalign_dropped", 32'h100, LS_W, 32'h1122_AB44);
        loadCheck("lh_201_zero", 32'h201, LS_H, 32'd0);
        loadCheck("oor_zero", 32'h4000, LS_W, 32'd0);
        loadCheck("subword_zero", MMIO, LS_BU, 32'd0);
        loadCheck("err_status_all", MMIO + 32'h14, LS_W, 32'h7);
        loadCheck("err_addr_first", MMIO + 32'h18, LS_W, 32'h102);
        storeOp(MMIO + 32'h1C, 32'd0, LS_W);
        checkOutput("clear_bus_err", {31'd0, bus_err}, 32'd0);
        loadCheck("clear_status", MMIO + 32'h14, LS_W, 32'd0);
        loadCheck("clear_addr", MMIO + 32'h18, LS_W, 32'd0);

        storeOp(MMIO + 32'h20, 32'h1234_5678, LS_W);
        loadCheck("unmapped_zero", MMIO + 32'h20, LS_W, 32'd0);
        checkOutput("unmapped_no_err", {31'd0, bus_err}, 32'd0);

`ifdef DTCM_TIMER_EN
        storeOp(MMIO + 32'h08, 32'd0, LS_W);
        storeOp(MMIO + 32'h04, 32'd0, LS_W);
        storeOp(MMIO + 32'h0C, 32'd10, LS_W);
        storeOp(MMIO + 32'h10, 32'd0, LS_W);
        repeat (8) @(posedge clk);
        #1;
        checkOutput("irq_before_cmp", {31'd0, timer_irq}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("irq_at_cmp", {31'd0, timer_irq}, 32'd1);

        storeOp(MMIO + 32'h08, 32'hFFFF_FFFF, LS_W);
        storeOp(MMIO + 32'h04, 32'hFFFF_FFFF, LS_W);
        checkOutput("irq_at_max", {31'd0, timer_irq}, 32'd1);
        @(posedge clk);
        #1;
        checkOutput("irq_max_hold", {31'd0, timer_irq}, 32'd1);
        loadCheck("mtime_wrapped_lo", MMIO + 32'h04, LS_W, 32'd0);
        checkOutput("irq_after_wrap", {31'd0, timer_irq}, 32'd0);
        loadCheck("mtime_wrapped_hi", MMIO + 32'h08, LS_W, 32'd0);

        storeOp(MMIO + 32'h08, 32'h0000_0001, LS_W);
        storeOp(MMIO + 32'h04, 32'hFFFF_FFFF, LS_W);
        loadCheck("tear_lo", MMIO + 32'h04, LS_W, 32'hFFFF_FFFF);
        loadCheck("tear_hi_shadow", MMIO + 32'h08, LS_W, 32'h0000_0001);
        loadCheck("cmp_lo_readback", MMIO + 32'h0C, LS_W, 32'd10);
        checkOutput("irq_pre_reset", {31'd0, timer_irq}, 32'd1);
`else
        loadCheck("notimer_mtime_lo", MMIO + 32'h04, LS_W, 32'd0);
        storeOp(MMIO + 32'h0C, 32'd5, LS_W);
        loadCheck("notimer_cmp_lo", MMIO + 32'h0C, LS_W, 32'd0);
        checkOutput("notimer_irq", {31'd0, timer_irq}, 32'd0);
`endif

        storeOp(MMIO, 32'd1, LS_W);
        checkOutput("tohost_val", tohost, 32'd1);
        checkOutput("tohost_valid_set", {31'd0, tohost_valid}, 32'd1);
        storeOp(MMIO, 32'd0, LS_W);
        checkOutput("tohost_zero", tohost, 32'd0);
        checkOutput("tohost_valid_sticky", {31'd0, tohost_valid}, 32'd1);
        storeOp(MMIO, 32'h2A, LS_W);
        loadCheck("tohost_readback", MMIO, LS_W, 32'h2A);
        storeOp(32'h108, 32'h1234_5678, LS_W);
        loadCheck("lw_108_misalign", 32'h109, LS_W, 32'd0);
        checkOutput("pre_reset_bus_err", {31'd0, bus_err}, 32'd1);

        rst_n = 1'b0;
        storeOp(32'h108, 32'hCAFE_F00D, LS_W);
        rst_n = 1'b1;
        checkOutput("reset_tohost", tohost, 32'd0);
        checkOutput("reset_tohost_valid", {31'd0, tohost_valid}, 32'd0);
        checkOutput("reset_bus_err", {31'd0, bus_err}, 32'd0);
        checkOutput("reset_irq", {31'd0, timer_irq}, 32'd0);
        loadCheck("reset_store_lost", 32'h108, LS_W, 32'h1234_5678);
        loadCheck("reset_err_status", MMIO + 32'h14, LS_W, 32'd0);
        loadCheck("reset_err_addr", MMIO + 32'h18, LS_W, 32'd0);
`ifdef DTCM_TIMER_EN
        loadCheck("reset_cmp_lo", MMIO + 32'h0C, LS_W, 32'hFFFF_FFFF);
        loadCheck("reset_cmp_hi", MMIO + 32'h10, LS_W, 32'hFFFF_FFFF);
        loadCheck("reset_shadow", MMIO + 32'h08, LS_W, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
